uart_frame_rx: RTL and testbench

Serial receiver for 8N1 UART frames (optional even parity): recovers bytes from the asynchronous `rx` line and presents each as a one-cycle `valid` strobe with `data`. Sits directly downstream of `uart_single_frame_tx` on the board link, or in loopback from its `tx` output. It is the receive half of the codebase's UART pair, and uses the same bit timing.

---
 rtl/uart_frame_rx.sv | 159 +++++++++++++++
 tb/tb_uart_frame_rx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_rx.sv
// 8N1 UART receiver with mid-bit sampling; define UART_RX_PARITY_EN to add an
// even-parity bit (11-bit frame) and make parity_err live.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge on rxs
// START  | timing to mid start bit, rejecting false starts
// DATA   | sampling 8 data bits, LSB first
// PARITY | sampling the even-parity bit (parity build only)
// STOP   | sampling the stop bit, issuing the end-of-frame pulse
// BREAK  | stop bit was low; waiting for the line to return high
module uart_frame_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
  localparam logic [2:0] BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd5;
`endif

  logic          rx_meta;
  logic          rxs;
  logic          rxs_q;
  logic          fall;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    nbits;
  logic [7:0]    shreg;
`ifdef UART_RX_PARITY_EN
  logic          par_bad;
`endif

  // Synchronizer and previous-sample register idle high so reset never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      rxs_q   <= rxs;
    end
  end

  assign fall = rxs_q & ~rxs;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      nbits     <= 3'd0;
      shreg     <= 8'h00;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      cnt <= cnt + 1'b1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (fall) state <= START;
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt   <= '0;
            nbits <= 3'd0;
            state <= rxs ? IDLE : DATA;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            shreg <= {rxs, shreg[7:1]};
            nbits <= nbits + 1'b1;
            if (nbits == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            par_bad <= rxs ^ (^shreg);
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rxs) begin
              // Returning mid stop bit leaves half a bit to catch the next start edge.
              state <= IDLE;
`ifdef UART_RX_PARITY_EN
              if (par_bad) begin
                parity_err <= 1'b1;
              end else begin
                data  <= shreg;
                valid <= 1'b1;
              end
`else
              data  <= shreg;
              valid <= 1'b1;
`endif
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end
        end
        BREAK: begin
          cnt <= '0;
          if (rxs) state <= IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: table of frames, scoreboard of expected
// end-of-frame pulses, plus reset, glitch and mid-frame-reset sequences.
module tb_uart_frame_rx;
  localparam int C = 16;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int K_VALID = 1;
  localparam int K_FERR  = 2;
  localparam int K_PERR  = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       valid, frame_err, parity_err, busy;

  uart_frame_rx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data(data), .valid(valid),
    .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic       par_flip;
    logic       stop;
    int         stop_len;
    int         gap;
    int         ek;
    logic [7:0] ed;
  } vec_t;

  typedef struct {
    int         kind;
    logic [7:0] d;
  } exp_t;

  vec_t vq[$];
  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_pulse = 0;
  int n_busy_rise = 0;
  int busy_rise_cyc = 0;
  int last_pulse_cyc = 0;
  int frame_t0 = 0;
  logic busy_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Pulse monitor: every end-of-frame pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy && !busy_q) begin
        busy_rise_cyc = cyc;
        n_busy_rise++;
      end
      if (valid || frame_err || parity_err) begin
        int kind;
        exp_t e;
        kind = valid ? K_VALID : (frame_err ? K_FERR : K_PERR);
        n_pulse++;
        last_pulse_cyc = cyc;
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_pulse: kind %0d data 0x%0h, expected no pulse", kind, data);
        end else begin
          e = sb.pop_front();
          if (kind != e.kind || data != e.d || $countones({valid, frame_err, parity_err}) != 1
              || busy != (kind == K_FERR)) begin
            n_err++;
            $display("FAIL pulse: kind %0d data 0x%0h busy %0b, expected kind %0d data 0x%0h busy %0b",
                     kind, data, busy, e.kind, e.d, (e.kind == K_FERR));
          end
        end
      end
    end
    busy_q = busy;
  end

  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop,
                            input int stop_len, input int gap);
    rx = 1'b0;
    frame_t0 = cyc;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (C) @(negedge clk);
    end
    if (P == 1) begin
      rx = (^b) ^ par_flip;
      repeat (C) @(negedge clk);
    end
    rx = stop;
    repeat (stop_len) @(negedge clk);
    rx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    int pulses_before;
    int rises_before;
    logic [7:0] b55;

    rst_n = 1'b0;
    rx = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx = ~rx;
    end
    check("reset_data", data, 8'h00);
    check("reset_valid", valid, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_parity_err", parity_err, 0);
    check("reset_busy", busy, 0);
    rx = 1'b1;
    rst_n = 1'b1;
    repeat (500) @(negedge clk);
    check("idle_pulses", n_pulse, 0);
    check("idle_busy", busy, 0);

    vq.push_back('{8'h41, 1'b0, 1'b1, C, 40, K_VALID, 8'h41});
    vq.push_back('{8'h00, 1'b0, 1'b1, C, 0,  K_VALID, 8'h00});
    vq.push_back('{8'hFF, 1'b0, 1'b1, C, 0,  K_VALID, 8'hFF});
    vq.push_back('{8'hA5, 1'b0, 1'b1, C, 40, K_VALID, 8'hA5});
    vq.push_back('{8'h5A, 1'b0, 1'b0, 40, 40, K_FERR, 8'hA5});
    vq.push_back('{8'h3C, 1'b0, 1'b1, C, 40, K_VALID, 8'h3C});
`ifdef UART_RX_PARITY_EN
    vq.push_back('{8'h07, 1'b0, 1'b1, C, 40, K_VALID, 8'h07});
    vq.push_back('{8'h07, 1'b1, 1'b1, C, 40, K_PERR,  8'h07});
`endif

    for (int v = 0; v < vq.size(); v++) begin
      e.kind = vq[v].ek;
      e.d = vq[v].ed;
      sb.push_back(e);
      send_frame(vq[v].b, vq[v].par_flip, vq[v].stop, vq[v].stop_len, vq[v].gap);
      if (v == 0) begin
        check("start_latency", busy_rise_cyc - frame_t0, 3);
        check("frame_latency", last_pulse_cyc - frame_t0, 3 + C / 2 + (9 + P) * C);
      end
    end
    check("table_pulses", n_pulse, vq.size());

    // Short low glitch: START entered, rejected at mid-bit, no pulse.
    pulses_before = n_pulse;
    rises_before = n_busy_rise;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_busy_rose", n_busy_rise - rises_before, 1);
    check("glitch_busy_end", busy, 0);
    check("glitch_pulses", n_pulse - pulses_before, 0);

    // Reset during data bit 4 of 8'h55.
    b55 = 8'h55;
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b55[i];
      repeat (C) @(negedge clk);
    end
    rx = b55[4];
    repeat (8) @(negedge clk);
    pulses_before = n_pulse;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_data", data, 8'h00);
    check("midreset_busy", busy, 0);
    rx = 1'b1;
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("midreset_pulses", n_pulse - pulses_before, 0);
    e.kind = K_VALID;
    e.d = 8'h12;
    sb.push_back(e);
    send_frame(8'h12, 1'b0, 1'b1, C, 40);
    check("after_reset_pulses", n_pulse - pulses_before, 1);

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
